// File: rtl/lsu_pkg.sv
// lsu_pkg: shared load/store funct3 encodings, LSU error codes and FSM state type.
package lsu_pkg;
  localparam logic [2:0] FUNCT3_LS_B  = 3'd0;
  localparam logic [2:0] FUNCT3_LS_H  = 3'd1;
  localparam logic [2:0] FUNCT3_LS_W  = 3'd2;
  localparam logic [2:0] FUNCT3_LS_BU = 3'd4;
  localparam logic [2:0] FUNCT3_LS_HU = 3'd5;
  localparam logic [1:0] LSU_ERR_OK       = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_FAULT    = 2'b10;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RESP} lsu_state_e;
endpackage

// File: rtl/lsu_check.sv
// lsu_check: combinational legality, alignment and range check producing the error code and RAM offset.
module lsu_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter int          RAM_WORDS = 1024
) (
  input  logic [31:0] addr_i,
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  output logic [1:0]  err_o,
  output logic [31:0] off_o
);
  localparam logic [31:0] LIMIT = 32'(RAM_WORDS * 4);
  logic illegal, misalign, fault;
  assign off_o    = addr_i - RAM_BASE;
  assign illegal  = funct3_i inside {3'd3, 3'd6, 3'd7} ||
                    (we_i && funct3_i inside {FUNCT3_LS_BU, FUNCT3_LS_HU});
  assign misalign = (funct3_i == FUNCT3_LS_W && addr_i[1:0] != 2'b00) ||
                    ((funct3_i == FUNCT3_LS_H || funct3_i == FUNCT3_LS_HU) && addr_i[0]);
  // Unsigned difference: addresses below the base wrap high and fault too.
  assign fault    = off_o >= LIMIT;
  assign err_o    = illegal ? LSU_ERR_ILLEGAL : misalign ? LSU_ERR_MISALIGN :
                    fault ? LSU_ERR_FAULT : LSU_ERR_OK;
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit driving a registered-read data RAM.
module lsu
  import lsu_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter int          RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd,
  output logic [1:0]  rsp_err,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [2:0]  ram_size,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd
);
  lsu_state_e  state_q;
  logic [31:0] off, off_q, rsp_rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  err, rsp_err_q;
  logic        acc;
  lsu_check #(.RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS)) u_check (
    .addr_i  (req_addr),
    .funct3_i(req_funct3),
    .we_i    (req_we),
    .err_o   (err),
    .off_o   (off)
  );
  assign req_ready = state_q == S_IDLE && !rst;
  assign acc       = req_valid && req_ready;
  assign ram_we    = acc && req_we && err == LSU_ERR_OK;
  // The RAM extends with the live size against its registered address, so hold both while waiting.
  assign ram_addr  = state_q == S_RD_WAIT ? off_q : off;
  assign ram_size  = state_q == S_RD_WAIT ? f3_q : req_funct3;
  assign ram_wd    = req_wd;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      off_q     <= '0;
      f3_q      <= '0;
      rsp_rd_q  <= '0;
      rsp_err_q <= LSU_ERR_OK;
    end else begin
      case (state_q)
        S_IDLE: if (acc) begin
          if (err == LSU_ERR_OK && !req_we) begin
            off_q   <= off;
            f3_q    <= req_funct3;
            state_q <= S_RD_WAIT;
          end else begin
            rsp_rd_q  <= '0;
            rsp_err_q <= err;
            state_q   <= S_RESP;
          end
        end
        S_RD_WAIT: begin
          rsp_rd_q  <= ram_rd;
          rsp_err_q <= LSU_ERR_OK;
          state_q   <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a byte-array reference model.
module tb_lsu;
  localparam logic [31:0] B = 32'h8000_0000;
  localparam int          WORDS = 1024;
  typedef struct packed {
    logic [3:0]  lat;
    logic [31:0] rd;
    logic [1:0]  err;
    logic        we_acc;
    logic        we_late;
    logic        rdy;
  } res_t;
  logic clk = 0;
  logic rst, req_valid, req_ready, req_we, rsp_valid, ram_we;
  logic [31:0] req_addr, req_wd, rsp_rd, ram_addr, ram_wd, ram_rd;
  logic [2:0]  req_funct3, ram_size;
  logic [1:0]  rsp_err;
  int checks = 0, errors = 0;
  logic [31:0] mem [0:WORDS-1];
  logic [7:0]  ref_mem [0:WORDS*4-1];
  logic [31:0] ra_q;
  always #5 clk = ~clk;
  lsu #(.RAM_BASE(B), .RAM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wd(req_wd), .rsp_valid(rsp_valid),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_size(ram_size), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );
  // Data RAM: registered address, read extension uses the live size.
  always @(posedge clk) begin
    ra_q <= ram_addr;
    if (ram_we)
      case (ram_size[1:0])
        2'd0:    mem[ram_addr[11:2]][{ram_addr[1:0], 3'b000} +: 8] <= ram_wd[7:0];
        2'd1:    mem[ram_addr[11:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_wd[15:0];
        default: mem[ram_addr[11:2]] <= ram_wd;
      endcase
  end
  always_comb begin
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem[ra_q[11:2]];
    b = w[{ra_q[1:0], 3'b000} +: 8];
    h = ra_q[1] ? w[31:16] : w[15:0];
    case (ram_size)
      3'd0:    ram_rd = {{24{b[7]}}, b};
      3'd4:    ram_rd = {24'd0, b};
      3'd1:    ram_rd = {{16{h[15]}}, h};
      3'd5:    ram_rd = {16'd0, h};
      default: ram_rd = w;
    endcase
  end
  function automatic int m_size(logic [2:0] f3);
    return f3 == 3'd2 ? 4 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
  endfunction
  function automatic logic [1:0] m_err(bit we, logic [31:0] a, logic [2:0] f3);
    logic [31:0] d;
    d = a - B;
    if (f3 == 3 || f3 == 6 || f3 == 7 || (we && (f3 == 4 || f3 == 5))) return 2'd3;
    if (a % m_size(f3) != 0) return 2'd1;
    if (d >= WORDS * 4) return 2'd2;
    return 2'd0;
  endfunction
  function automatic logic [31:0] m_load(logic [31:0] a, logic [2:0] f3);
    logic [31:0] d;
    logic [7:0] b0, b1, b2, b3;
    d = a - B;
    b0 = ref_mem[d[11:0]];
    b1 = ref_mem[d[11:0] + 12'd1];
    b2 = ref_mem[d[11:0] + 12'd2];
    b3 = ref_mem[d[11:0] + 12'd3];
    case (f3)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd4:    return {24'd0, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd5:    return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction
  function automatic res_t mk(int lat, logic [31:0] rd, logic [1:0] err, bit we);
    res_t r;
    r.lat = 4'(lat); r.rd = rd; r.err = err; r.we_acc = we; r.we_late = 0; r.rdy = 0;
    return r;
  endfunction
  // Drives one request, measures response latency and RAM write activity; also predicts the result.
  task automatic op(input bit we, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                    output res_t act, output res_t exp);
    logic [1:0] e;
    logic [31:0] d;
    int n;
    e = m_err(we, a, f3);
    exp = mk((e == 0 && !we) ? 2 : 1, (e == 0 && !we) ? m_load(a, f3) : 32'd0, e, e == 0 && we);
    n = 0;
    @(negedge clk); #1;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    req_valid = 1; req_we = we; req_addr = a; req_funct3 = f3; req_wd = wd; #1;
    act.we_acc = ram_we;
    act.we_late = 0;
    @(posedge clk); @(negedge clk);
    req_valid = 0; req_we = 0; #1;
    n = 1;
    while (!rsp_valid && n < 10) begin
      act.we_late |= ram_we;
      @(negedge clk); #1; n++;
    end
    act.we_late |= ram_we;
    act.lat = 4'(n); act.rd = rsp_rd; act.err = rsp_err; act.rdy = req_ready;
    d = a - B;
    if (e == 0 && we)
      for (int i = 0; i < m_size(f3); i++) ref_mem[d[11:0] + 12'(i)] = wd[8*i +: 8];
  endtask
  task automatic test_reset();
    rst = 1; req_valid = 1; req_we = 1; req_addr = B; req_funct3 = 3'd2; req_wd = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_rd, rsp_err, req_ready, ram_we} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b rd=%h err=%b ready=%b we=%b, want all 0",
               rsp_valid, rsp_rd, rsp_err, req_ready, ram_we);
    end
    req_valid = 0; req_we = 0;
    @(negedge clk); rst = 0; #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask
  task automatic test_sw_lw();
    res_t a, x, e;
    op(1, B + 32'h10, 3'd2, 32'hDEAD_BEEF, a, e);
    x = mk(1, 0, 0, 1); checks++;
    if (a !== x) begin errors++; $display("FAIL sw_deadbeef: got %h want %h", a, x); end
    op(0, B + 32'h10, 3'd2, 0, a, e);
    x = mk(2, 32'hDEAD_BEEF, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lw_deadbeef: got %h want %h", a, x); end
    repeat (2) @(negedge clk);
    #1; checks++;
    if (rsp_rd !== 32'hDEAD_BEEF || rsp_err !== 2'd0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_hold: rd=%h err=%b valid=%b want deadbeef 00 0", rsp_rd, rsp_err, rsp_valid);
    end
  endtask
  task automatic test_byte();
    res_t a, x, e;
    op(1, B + 32'h10, 3'd2, 32'h0, a, e);
    op(1, B + 32'h13, 3'd0, 32'h80, a, e);
    x = mk(1, 0, 0, 1); checks++;
    if (a !== x) begin errors++; $display("FAIL sb: got %h want %h", a, x); end
    op(0, B + 32'h13, 3'd0, 0, a, e);
    x = mk(2, 32'hFFFF_FF80, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lb: got %h want %h", a, x); end
    op(0, B + 32'h13, 3'd4, 0, a, e);
    x = mk(2, 32'h0000_0080, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lbu: got %h want %h", a, x); end
    op(0, B + 32'h10, 3'd2, 0, a, e);
    x = mk(2, 32'h8000_0000, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lw_after_sb: got %h want %h", a, x); end
  endtask
  task automatic test_half();
    res_t a, x, e;
    op(1, B + 32'h10, 3'd2, 32'h8001_7FFF, a, e);
    op(0, B + 32'h12, 3'd1, 0, a, e);
    x = mk(2, 32'hFFFF_8001, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lh_hi: got %h want %h", a, x); end
    op(0, B + 32'h12, 3'd5, 0, a, e);
    x = mk(2, 32'h0000_8001, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lhu_hi: got %h want %h", a, x); end
    op(0, B + 32'h10, 3'd1, 0, a, e);
    x = mk(2, 32'h0000_7FFF, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lh_lo: got %h want %h", a, x); end
  endtask
  task automatic test_misalign();
    res_t a, x, e;
    op(0, B + 32'h2, 3'd2, 0, a, e);
    x = mk(1, 0, 1, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lw_misalign: got %h want %h", a, x); end
    op(1, B + 32'h1, 3'd1, 32'h1234, a, e);
    x = mk(1, 0, 1, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL sh_misalign: got %h want %h", a, x); end
    op(0, B, 3'd2, 0, a, e);
    x = mk(2, 0, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lw_prior: got %h want %h", a, x); end
  endtask
  task automatic test_fault_illegal();
    res_t a, x, e;
    op(0, B + 32'(WORDS * 4), 3'd2, 0, a, e);
    x = mk(1, 0, 2, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lw_top_fault: got %h want %h", a, x); end
    op(0, B - 32'd4, 3'd2, 0, a, e);
    x = mk(1, 0, 2, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lw_wrap_fault: got %h want %h", a, x); end
    op(1, B + 32'h20, 3'd3, 32'h5555_5555, a, e);
    x = mk(1, 0, 3, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL st_f3_3: got %h want %h", a, x); end
    op(1, B + 32'h20, 3'd5, 32'h5555_5555, a, e);
    x = mk(1, 0, 3, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL st_hu: got %h want %h", a, x); end
    op(0, B + 32'(WORDS * 4) + 32'd2, 3'd2, 0, a, e);
    x = mk(1, 0, 1, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL prio_mis_over_fault: got %h want %h", a, x); end
    op(1, B + 32'h1, 3'd7, 0, a, e);
    x = mk(1, 0, 3, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL prio_ill_over_mis: got %h want %h", a, x); end
    op(0, B + 32'h20, 3'd2, 0, a, e);
    x = mk(2, 0, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL no_write_on_err: got %h want %h", a, x); end
  endtask
  task automatic test_reset_mid();
    res_t a, x, e;
    bit seen;
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    req_valid = 1; req_we = 0; req_addr = B + 32'h10; req_funct3 = 3'd2;
    @(posedge clk); @(negedge clk);
    req_valid = 0; rst = 1; #1;
    seen = rsp_valid | ram_we;
    @(negedge clk); rst = 0; #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b want 1", req_ready); end
    repeat (3) begin seen |= rsp_valid | ram_we; @(negedge clk); #1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_drops_load: saw valid/we=%b want 0", seen); end
    op(0, B + 32'h10, 3'd2, 0, a, e);
    x = mk(2, 32'h8001_7FFF, 0, 0); checks++;
    if (a !== x) begin errors++; $display("FAIL lw_after_rst: got %h want %h", a, x); end
  endtask
  task automatic test_random();
    res_t a, e;
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] addr;
    logic [2:0] f3;
    int r;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      addr = r == 0 ? $urandom : r == 1 ? B + 32'(WORDS * 4) - 32'($urandom_range(0, 8)) :
             B + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      if (r > 3) addr = addr & ~32'(m_size(f3) - 1);
      op(1'($urandom_range(0, 1)), addr, f3, $urandom, a, e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL rand[%0d] addr=%h f3=%0d: got %h want %h", i, addr, f3, a, e);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 0;
    for (int i = 0; i < WORDS * 4; i++) ref_mem[i] = 0;
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_funct3 = 0; req_wd = 0;
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_misalign();
    test_fault_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit between the core's memory stage and the data RAM.
- Accepts one load/store request at a time over a valid/ready handshake.
- Checks alignment, address range and funct3 legality, then drives the RAM port (registered read, byte/half/word write by funct3).
- Returns a single-cycle response pulse carrying read data and an error code.

Parameters:
- RAM_BASE, 32'h0000_0000, byte base address of the RAM window.
- RAM_WORDS, 1024, RAM depth in 32-bit words; must match the RAM instance SIZE.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  FUNCT3_LS_* access size/sign.
- req_wd  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rd  out  32  load result, already extended by the RAM; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM byte offset (req_addr - RAM_BASE).
- ram_size  out  3  RAM funct3.
- ram_wd  out  32  RAM write data.
- ram_rd  in  32  RAM read data, valid the cycle after the address is presented.

Behaviour:
- States: IDLE, RD_WAIT, RESP. Reset state is IDLE; rsp_valid=0, rsp_rd=0, rsp_err=0.
- req_ready=1 only in IDLE and only when rst=0. A request is accepted when req_valid && req_ready.
- Checks on accept, applied in priority order:
  - illegal: funct3 in {3,6,7}, or a store with HU/BU.
  - misaligned: W requires addr[1:0]==0; H/HU require addr[0]==0.
  - fault: (addr - RAM_BASE) >= RAM_WORDS*4, computed as an unsigned 32-bit difference, so addresses below the base wrap and fault.
- Accept with error: ram_we stays 0; latch the error code; go to RESP.
- Accept valid store:
  - ram_we=1 combinationally in the accept cycle.
  - ram_addr, ram_size and ram_wd are taken directly from the request.
  - Go to RESP; the write commits at that clock edge.
- Accept valid load:
  - Drive ram_addr/ram_size from the request.
  - Latch the offset and funct3; go to RD_WAIT.
- RD_WAIT:
  - ram_addr and ram_size are driven from the latched values. ram_size must be held because the RAM's extension mux uses the live size with its registered address.
  - Register ram_rd into rsp_rd; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0; then return to IDLE.
- Latency, with accept at cycle T:
  - store response at T+1;
  - load response at T+2.
  - Next accept no earlier than T+2 (store) or T+3 (load).
- ram_we=0 in every state except the accept cycle of a valid store, and always 0 while rst=1.
- In IDLE without a request, ram_addr/ram_size follow the request inputs and ram_we=0 (harmless read).
- rsp_rd and rsp_err hold their values after RESP until the next response.
- Reset mid-operation: rst in any state returns to IDLE in the next cycle, with no rsp_valid and no RAM write; the abandoned load is dropped.

Decomposition:
- Shared constants: FUNCT3_LS_* stay in the existing shared constants include; add LSU_ERR_OK/MISALIGN/FAULT/ILLEGAL (2-bit) there.
- Sub-module lsu_check: purely combinational, takes addr, funct3 and we, produces the err code and the RAM offset. It holds the range/alignment logic so it can be unit-tested.
- The FSM and holding registers stay in lsu.

Test Plan:
1. SW 0xDEADBEEF @RAM_BASE+0x10, then LW same address -> store rsp_valid at T+1 with err 00; load rsp_rd=0xDEADBEEF at T+2 with err 00.
2. SW 0 @+0x10, SB 0x80 @+0x13, then LB @+0x13 -> 0xFFFFFF80; LBU @+0x13 -> 0x00000080; LW @+0x10 -> 0x80000000.
3. SW 0x80017FFF @+0x10, then:
   - LH @+0x12 -> 0xFFFF8001;
   - LHU @+0x12 -> 0x00008001;
   - LH @+0x10 -> 0x00007FFF.
4. LW @+0x2 -> err 01, rd 0; SH 0x1234 @+0x1 -> err 01, ram_we never high; following LW @+0x0 returns the prior contents.
5. LW @RAM_BASE+RAM_WORDS*4 -> err 10; store with funct3 3'b011 -> err 11; store with funct3 HU -> err 11; ram_we stays 0 throughout.
6. Accept LW, assert rst for 1 cycle during RD_WAIT -> no rsp_valid; req_ready=1 in the cycle after rst drops; a new LW completes normally.
